// File: rtl/result_display_if.sv
// result_display_if
//   Valid/ready handshake that carries the 4-bit sign-magnitude result from the
//   signed add/sub stage into the display block.
//
//   Signals
//     in_valid   upstream -> display   result_in holds a result to be taken
//     in_ready   display  -> upstream  display accepts result_in this cycle
//     result_in  upstream -> display   [3] sign, [2:0] magnitude
//
//   Modports
//     master  the add/sub stage (drives in_valid/result_in)
//     slave   the display block (drives in_ready)
interface result_display_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] result_in;

    modport master (
        output in_valid,
        output result_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  result_in,
        output in_ready
    );
endinterface

// File: rtl/result_display.sv
// result_display
//   Captures the signed add/sub result through a valid/ready handshake and shows
//   it on a 2-digit, time-multiplexed, common-anode 7-segment display:
//   digit 0 is the magnitude (0..7), digit 1 is a minus sign or blank.
//
//   Parameters
//     REFRESH_DIV   clocks each digit stays lit (>= 2); one frame = 2 digit slots
//     BLINK_FRAMES  frames of blinking after each capture (>= 1, blink build only)
//
//   Ports
//     clk   in   system clock, rising edge
//     rst   in   asynchronous, active-high reset
//     up    slave side of result_display_if (in_valid, in_ready, result_in)
//     seg   out  active-low segments {g,f,e,d,c,b,a}
//     an    out  active-low digit enables: an[0] magnitude digit, an[1] sign digit
//
//   Build option
//     FRESH_BLINK_EN  when defined, every newly captured value blinks for
//                     BLINK_FRAMES frames (even frames dark, odd frames lit) and
//                     no new value is accepted until the blink is over. When not
//                     defined, every valid result is taken immediately and the
//                     display is never blanked.
module result_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 4
) (
    input  logic            clk,
    input  logic            rst,
    result_display_if.slave up,
    output logic [6:0]      seg,
    output logic [1:0]      an
);

    // Parameter sanity: a slot needs at least two clocks and a blink at least
    // one frame, otherwise the counters below degenerate.
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("result_display: REFRESH_DIV must be >= 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
        $error("result_display: BLINK_FRAMES must be >= 1");
    end

    localparam int               DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [1:0] AN_MAG    = 2'b10;
    localparam logic [1:0] AN_SIGN   = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;

    logic [DIV_W-1:0] div_cnt;
    logic             digit_sel;
    logic [3:0]       result_reg;
    logic             slot_wrap;
    logic             capture;
    logic             dark;
    logic [6:0]       mag_code;
    logic [6:0]       seg_next;
    logic [1:0]       an_next;

    // A transfer happens whenever both sides agree on the same rising edge.
    assign capture   = up.in_valid && up.in_ready;
    assign slot_wrap = (div_cnt == DIV_LAST);

    // Slot timer: div_cnt runs 0..REFRESH_DIV-1, and each wrap hands the
    // display over to the other digit. It is free running and never restarted
    // by a capture, so the refresh rhythm is independent of the data traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_sel <= 1'b0;
        end else if (slot_wrap) begin
            div_cnt   <= '0;
            digit_sel <= ~digit_sel;
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // Result holding register. The value is stored exactly as received; no
    // arithmetic is ever done on it, the sign only decides what digit 1 shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= 4'b0000;
        end else if (capture) begin
            result_reg <= up.result_in;
        end
    end

`ifdef FRESH_BLINK_EN
    typedef enum logic {
        IDLE,
        BLINK
    } state_t;

    localparam int              FC_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    state_t          state;
    state_t          state_next;
    logic [FC_W-1:0] frame_cnt;
    logic            frame_end;

    // A frame is a magnitude slot followed by a sign slot, so a frame closes
    // on the wrap that takes digit_sel from 1 back to 0.
    assign frame_end = slot_wrap && digit_sel;

    // Blink state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Blink sequencing. While idle the block is ready and the first capture
    // starts a blink. During the blink the handshake is closed, so held-off
    // results stay with the upstream stage. The blink ends on the frame end
    // that completes the last blink frame; ready comes back with IDLE.
    always_comb begin
        state_next  = state;
        up.in_ready = 1'b0;
        case (state)
            IDLE: begin
                up.in_ready = 1'b1;
                if (up.in_valid) begin
                    state_next = BLINK;
                end
            end
            BLINK: begin
                if (frame_end && (frame_cnt == FC_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frames elapsed since the capture. Restarting at the capture edge means
    // frame 0 is whatever is left of the current frame, so it can be short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (capture) begin
            frame_cnt <= '0;
        end else if ((state == BLINK) && frame_end) begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    // Even blink frames switch both digits off; odd ones show them normally.
    assign dark = (state == BLINK) && !frame_cnt[0];
`else
    // Without blinking the display never stalls the add/sub stage.
    assign up.in_ready = 1'b1;
    assign dark        = 1'b0;
`endif

    // Digit decode. The magnitude pattern table is the standard active-low
    // 7-segment font for 0..7. The sign digit shows a minus only for a real
    // negative number, so negative zero reads as a plain "0".
    always_comb begin
        mag_code = SEG_BLANK;
        case (result_reg[2:0])
            3'd0:    mag_code = 7'h40;
            3'd1:    mag_code = 7'h79;
            3'd2:    mag_code = 7'h24;
            3'd3:    mag_code = 7'h30;
            3'd4:    mag_code = 7'h19;
            3'd5:    mag_code = 7'h12;
            3'd6:    mag_code = 7'h02;
            3'd7:    mag_code = 7'h78;
            default: mag_code = SEG_BLANK;
        endcase

        seg_next = mag_code;
        an_next  = AN_MAG;
        if (digit_sel) begin
            an_next = AN_SIGN;
            if (result_reg[3] && (result_reg[2:0] != 3'd0)) begin
                seg_next = SEG_MINUS;
            end else begin
                seg_next = SEG_BLANK;
            end
        end

        if (dark) begin
            an_next = AN_OFF;
        end
    end

    // Output registers. They sample the slot and value as they stand after the
    // previous edge, so a capture coinciding with a slot change shows the new
    // value in the new slot one edge later, and the pins never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// tb_result_display
//   Self-checking bench for result_display with REFRESH_DIV=4, BLINK_FRAMES=2.
//   Expected pins come from a reference that works purely in terms of "edges
//   since reset": which slot an edge belongs to, which frame a blink is in and
//   which value was last accepted. Directed loads cover the interesting values
//   (-6, -0, a mid-slot load, an async reset mid-slot), then a randomized run
//   with a hold-until-accepted upstream follows.
module tb_result_display;

    localparam int RD = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] an;

    result_display_if bus ();

    result_display #(
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .up  (bus),
        .seg (seg),
        .an  (an)
    );

    // 100 MHz-style free running clock.
    always #5 clk = ~clk;

    int         errors;
    int         checks;
    int         tick;
    logic [3:0] modelValue;
    bit         blinkActive;
    int         blinkStart;
    bit         lastFire;
    bit         pend;
    logic [3:0] pdata;

    logic [6:0] magCode [8] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at tick %0d: got %0h, expected %0h",
                     tag, tick, got, exp);
        end
    endtask

    // First frame end strictly after the capture edge. Frame ends fall on
    // edges that are multiples of 2*RD counted from reset release.
    function automatic int firstFrameEnd();
        return (blinkStart / (2 * RD) + 1) * 2 * RD;
    endfunction

    // True when the block is blinking after edge m.
    function automatic bit inBlink(input int m);
        int lastEdge;
        if (!blinkActive) return 1'b0;
        lastEdge = firstFrameEnd() + (BF - 1) * 2 * RD;
        return (m >= blinkStart) && (m < lastEdge);
    endfunction

    // Blink frame number after edge m (frame 0 starts at the capture).
    function automatic int frameIdx(input int m);
        int f1;
        f1 = firstFrameEnd();
        if (m < f1) return 0;
        return (m - f1) / (2 * RD) + 1;
    endfunction

    // One clock of stimulus: drive the handshake, check ready, take the edge,
    // predict what the pins must show after it and compare.
    task automatic applyStimulus(input bit v, input logic [3:0] d);
        bit         readyExp;
        int         n;
        logic [6:0] segExp;
        logic [1:0] anExp;
        bus.in_valid  = v;
        bus.result_in = d;
        readyExp = !inBlink(tick);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(readyExp));
        @(posedge clk);
        n = tick + 1;
        if (((n - 1) / RD) % 2 == 0) begin
            anExp  = 2'b10;
            segExp = magCode[modelValue[2:0]];
        end else begin
            anExp  = 2'b01;
            segExp = (modelValue[3] && modelValue[2:0] != 3'd0) ? 7'h3F : 7'h7F;
        end
        if (inBlink(n - 1) && (frameIdx(n - 1) % 2 == 0)) begin
            anExp = 2'b11;
        end
        lastFire = v && readyExp;
        if (lastFire) begin
            modelValue = d;
`ifdef FRESH_BLINK_EN
            blinkActive = 1'b1;
            blinkStart  = n;
`endif
        end
        tick = n;
        #1;
        checkOutput("seg", 32'(seg), 32'(segExp));
        checkOutput("an", 32'(an), 32'(anExp));
    endtask

    // Idle cycles with junk on the data lines.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            applyStimulus(1'b0, 4'($urandom));
        end
    endtask

    // Offer a value and hold it until accepted, bounded in cycles.
    task automatic loadValue(input logic [3:0] d);
        int waited;
        waited   = 0;
        lastFire = 1'b0;
        while (!lastFire && waited < 100) begin
            applyStimulus(1'b1, d);
            waited++;
        end
        bus.in_valid = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges, mid-slot.
    task automatic pulseReset();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_an", 32'(an), 32'h3);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);
        #2 rst = 1'b0;
        tick        = 0;
        modelValue  = 4'b0000;
        blinkActive = 1'b0;
        blinkStart  = 0;
        pend        = 1'b0;
    endtask

    // Main sequence: reset checks, directed loads, then a randomized run.
    initial begin
        errors        = 0;
        checks        = 0;
        tick          = 0;
        modelValue    = 4'b0000;
        blinkActive   = 1'b0;
        blinkStart    = 0;
        lastFire      = 1'b0;
        pend          = 1'b0;
        pdata         = 4'b0000;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.result_in = 4'b0000;

        #12;
        checkOutput("init_seg", 32'(seg), 32'h7F);
        checkOutput("init_an", 32'(an), 32'h3);
        checkOutput("init_in_ready", 32'(bus.in_ready), 32'h1);
        #2 rst = 1'b0;

        idle(10);
        loadValue(4'b1110);
        idle(12);
        loadValue(4'b1000);
        idle(12);
        idle(1);
        loadValue(4'b0011);
        idle(10);
        pulseReset();
        idle(6);
        loadValue(4'b0101);
        idle(3);
        applyStimulus(1'b1, 4'b0001);
        applyStimulus(1'b1, 4'b0001);
        idle(20);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                pulseReset();
            end
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend  = 1'b1;
                pdata = 4'($urandom);
            end
            applyStimulus(pend, pdata);
            if (lastFire) begin
                pend = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
